xts_seq_ctrl: RTL and testbench
===============================

Name: xts_seq_ctrl

Overview:
- Sequencer for one XTS data unit of 128-bit blocks.
- Drives the load, read-advance and write-advance controls of the existing tweak module:
  - alpha is used for blocks entering the AES core.
  - oldalpha is used for blocks leaving it.
- Gates block issue into the AES pipeline with an in-flight credit limit.
- Retires results in order to the output buffer, then reports completion.

Parameters:
- BLK_W, 16: width of block count; max data unit is 2^BLK_W-1 blocks.
- MAX_INFLIGHT, 4: AES pipeline depth; maximum blocks issued but not yet retired.
- INF_W, $clog2(MAX_INFLIGHT+1): in-flight counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  begin data unit; sampled only in IDLE.
- abort  in  1  cancel current data unit.
- tweak_in  in  128  encrypted initial tweak for the data unit.
- num_blocks  in  BLK_W  blocks in the data unit.
- in_valid  in  1  plaintext/ciphertext block available.
- in_ready  out  1  block accepted this cycle when in_valid is also high.
- res_valid  in  1  AES core result available (in order).
- res_ready  out  1  result consumed.
- out_valid  out  1  result presented to output buffer.
- out_ready  in  1  output buffer can accept.
- tk_ud  out  1  tweak load strobe.
- tk_read  out  1  alpha advance strobe.
- tk_write  out  1  oldalpha advance strobe.
- tweak_0  out  128  tweak load value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (n_rst low, asynchronous):
  - State IDLE; issued, retired and inflight counters 0.
  - tweak_0 = 0; all strobes, in_ready, res_ready, out_valid, busy and done = 0.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches num_blocks and tweak_in (into tweak_0).
  - Next state is LOAD, or DONE if num_blocks==0.
- LOAD:
  - tk_ud=1 for exactly one cycle; next state RUN.
  - No issue is allowed in LOAD, so alpha and oldalpha both hold the tweak when RUN starts.
- RUN:
  - in_ready = (issued < num) && (inflight < MAX_INFLIGHT). It is combinational and must not depend on in_valid.
  - Issue fire = in_valid && in_ready. On fire: tk_read=1 in the same cycle, issued+1, inflight+1.
  - The block XORs with the current alpha; the advanced alpha is visible the next cycle.
  - When issued reaches num, go to DRAIN.
- Retire (RUN and DRAIN):
  - out_valid = res_valid; res_ready = out_ready.
  - Retire fire = res_valid && out_ready. On fire: tk_write=1, retired+1, inflight-1.
- Simultaneous issue and retire: inflight is unchanged; both strobes are asserted.
- DRAIN: in_ready=0. When retired reaches num, go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in DONE.
- abort:
  - Highest priority in any non-IDLE state: next state IDLE, counters cleared, no done pulse.
  - All strobes are 0 in the abort cycle.
  - A start arriving in the same cycle as abort is ignored.
- start outside IDLE is ignored. num_blocks and tweak_in are sampled only on an accepted start.
- Counter rules:
  - issued and retired are BLK_W bits and never exceed num; no wrap.
  - inflight never exceeds MAX_INFLIGHT and never underflows.
  - res_valid arriving with inflight==0 is a protocol error: ignored, res_ready=0.

Optional Feature:
- Macro: XTS_PERF_EN.
- Defined: adds output stall_cnt [31:0].
  - Increments each RUN cycle where in_valid=1, issued<num and inflight==MAX_INFLIGHT.
  - Saturates at 32'hFFFFFFFF; cleared on accepted start; holds its value in IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package xts_pkg holds:
  - State enum xts_state_t (IDLE, LOAD, RUN, DRAIN, DONE).
  - BLK_W default constant.
  - Tweak width constant TWEAK_W=128.
- One sub-module: xts_credit_cnt (inflight up/down counter).
  - Inputs: inc, dec, clr.
  - Outputs: full, empty.
  - Instantiated once.

Test Plan:
- Basic: reset, start with num_blocks=3, tweak_in=128'h1; in_valid and out_ready held high; AES model of latency 2.
  - tk_ud exactly 1 cycle after start.
  - 3 tk_read pulses, 3 tk_write pulses.
  - done pulses once, busy drops the next cycle.
- Credit stall: MAX_INFLIGHT=4, num_blocks=10, AES latency 8.
  - in_ready drops after 4 issues; inflight never exceeds 4.
  - stall_cnt>0 when XTS_PERF_EN is defined.
- Backpressure: out_ready=0 for 5 cycles mid-run.
  - res_ready=0 and no tk_write during those cycles.
  - retired order preserved; done only after the 10th retire.
- Zero length: start with num_blocks=0.
  - No tk_ud, tk_read or tk_write.
  - done pulses 1 cycle after start.
- Abort: abort in DRAIN with 2 blocks in flight.
  - IDLE next cycle, no done pulse, counters 0.
  - A new start with num_blocks=1 then completes normally.
- Async reset mid-RUN:
  - All outputs 0 immediately on n_rst low.
  - start ignored while reset is asserted.

Source files
------------

// File: rtl/xts_pkg.sv
// Shared types and constants for the XTS data-unit sequencer.
// The optional stall counter is enabled by defining XTS_PERF_EN.
package xts_pkg;

  localparam int BLK_W_DEF = 16;
  localparam int TWEAK_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } xts_state_t;

endpackage

// File: rtl/xts_credit_cnt.sv
// In-flight block counter between AES issue and retire.
// Saturates at MAX and never underflows.
module xts_credit_cnt
  import xts_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic full,
  output logic empty
);

  localparam logic [W-1:0] CMAX = W'(MAX);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  assign full = (cnt == CMAX);
  assign empty = (cnt == '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + ONE;
    end else if (dec && !inc && !empty) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/xts_seq_ctrl.sv
// Sequencer for one XTS data unit: tweak strobes, AES credit, in-order retire.
// Define XTS_PERF_EN to add the stall_cnt performance counter output.
module xts_seq_ctrl
  import xts_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [TWEAK_W-1:0] tweak_in,
  input  logic [BLK_W-1:0]   num_blocks,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               res_valid,
  output logic               res_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               tk_ud,
  output logic               tk_read,
  output logic               tk_write,
  output logic [TWEAK_W-1:0] tweak_0,
  output logic               busy,
  output logic               done
`ifdef XTS_PERF_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [BLK_W-1:0] ONE = BLK_W'(1);

  xts_state_t state, nxt;

  logic [BLK_W-1:0] num;
  logic [BLK_W-1:0] issued;
  logic [BLK_W-1:0] retired;
  logic full, empty;
  logic active, kill;
  logic start_ok;
  logic iss_fire, ret_fire;

  assign busy = (state != IDLE);
  assign kill = abort && busy;
  assign active = (state == RUN) || (state == DRAIN);
  assign start_ok = (state == IDLE) && start && !abort;

  // Results are only legal while something is in flight.
  assign in_ready = (state == RUN) && !abort &&
                    (issued < num) && !full;
  assign out_valid = active && !abort && !empty && res_valid;
  assign res_ready = active && !abort && !empty && out_ready;

  assign iss_fire = in_valid && in_ready;
  assign ret_fire = res_valid && res_ready;

  assign tk_ud = (state == LOAD) && !abort;
  assign tk_read = iss_fire;
  assign tk_write = ret_fire;
  assign done = (state == DONE) && !abort;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          nxt = (num_blocks == '0) ? DONE : LOAD;
        end
      end
      LOAD: nxt = RUN;
      RUN: begin
        if (iss_fire && (issued + ONE == num)) begin
          nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (ret_fire && (retired + ONE == num)) begin
          nxt = DONE;
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (kill) begin
      nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      num <= '0;
      tweak_0 <= '0;
      issued <= '0;
      retired <= '0;
    end else begin
      state <= nxt;
      if (start_ok) begin
        num <= num_blocks;
        tweak_0 <= tweak_in;
        issued <= '0;
        retired <= '0;
      end else if (kill) begin
        issued <= '0;
        retired <= '0;
      end else begin
        if (iss_fire) begin
          issued <= issued + ONE;
        end
        if (ret_fire) begin
          retired <= retired + ONE;
        end
      end
    end
  end

  xts_credit_cnt #(
    .MAX(MAX_INFLIGHT),
    .W  (INF_W)
  ) u_credit (
    .clk  (clk),
    .n_rst(n_rst),
    .inc  (iss_fire),
    .dec  (ret_fire),
    .clr  (start_ok || kill),
    .full (full),
    .empty(empty)
  );

`ifdef XTS_PERF_EN
  // Cycles where a ready block waits only on AES credit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && in_valid &&
                 (issued < num) && full &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xts_seq_ctrl.sv
// Scoreboard bench for xts_seq_ctrl with a tweak-register model
// and an in-order AES pipeline model of configurable latency.
module tb_xts_seq_ctrl;

  localparam int BLK_W = 16;
  localparam int MAXI = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic res_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] tweak_in = '0;
  logic [BLK_W-1:0] num_blocks = '0;
  logic in_ready, res_ready, out_valid;
  logic tk_ud, tk_read, tk_write, busy, done;
  logic [127:0] tweak_0;
`ifdef XTS_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xts_seq_ctrl #(
    .BLK_W(BLK_W),
    .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .abort     (abort),
    .tweak_in  (tweak_in),
    .num_blocks(num_blocks),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tk_ud     (tk_ud),
    .tk_read   (tk_read),
    .tk_write  (tk_write),
    .tweak_0   (tweak_0),
    .busy      (busy),
    .done      (done)
`ifdef XTS_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    int rdy;
    logic [127:0] tw;
  } aes_t;

  aes_t pipe_q[$];
  logic [127:0] sb_q[$];
  logic [127:0] alpha = '0;
  logic [127:0] oldalpha = '0;

  int n_ud, n_rd, n_wr, n_done;
  int ud_c, done_c, last_ret_c;
  int peak, exp_stall, bp_viol, abort_infl;
  logic busy_after;

  function automatic logic [127:0] mulx(input logic [127:0] t);
    logic [127:0] r;
    r = {t[126:0], 1'b0};
    if (t[127]) r[7:0] = r[7:0] ^ 8'h87;
    return r;
  endfunction

  // Enter and leave on a falling edge.
  task automatic run_unit(input int num, input logic [127:0] tw,
                          input int lat, input int bp_from,
                          input int bp_len, input int abort_c,
                          input int max_cyc);
    int iss, ret;
    logic [127:0] exp_next, e;
    aes_t p;
    logic s_ud, s_rd, s_wr, exp_ir, fin, aborted;
    logic [127:0] s_t0;
    iss = 0; ret = 0; exp_next = tw; fin = 0; aborted = 0;
    n_ud = 0; n_rd = 0; n_wr = 0; n_done = 0;
    ud_c = -1; done_c = -1; last_ret_c = -1;
    peak = 0; exp_stall = 0; bp_viol = 0; abort_infl = -1;
    busy_after = 1'bx;
    pipe_q.delete();
    sb_q.delete();
    tweak_in = tw;
    num_blocks = num[BLK_W-1:0];
    in_valid = 1'b1;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      start = (c == 0) || (c == abort_c);
      abort = (c == abort_c);
      if (c == abort_c) num_blocks = 16'd5;
      out_ready = !(c >= bp_from && c < bp_from + bp_len);
      res_valid = (pipe_q.size() > 0) && (pipe_q[0].rdy <= c);
      #1;
      exp_ir = !aborted && !abort && c >= 2 &&
               iss < num && (iss - ret) < MAXI;
      checks++;
      if (in_ready !== exp_ir) begin
        errors++;
        $display("FAIL in_ready c=%0d got %b exp %b", c, in_ready, exp_ir);
      end
      checks++;
      if (tk_read !== (exp_ir && in_valid)) begin
        errors++;
        $display("FAIL tk_read c=%0d got %b exp %b",
                 c, tk_read, exp_ir && in_valid);
      end
      if (c >= 2 && !aborted && !abort && iss < num &&
          (iss - ret) == MAXI) exp_stall++;
      if (tk_ud) begin n_ud++; ud_c = c; end
      if (tk_read) n_rd++;
      if (tk_write) n_wr++;
      if (done) begin n_done++; done_c = c; end
      if (!out_ready && (res_ready || tk_write)) bp_viol++;
      if (abort) begin
        abort_infl = iss - ret;
        checks++;
        if ({tk_ud, tk_read, tk_write, done} !== 4'b0) begin
          errors++;
          $display("FAIL abort_strobes got %b exp 0000",
                   {tk_ud, tk_read, tk_write, done});
        end
      end
      if (in_valid && in_ready) begin
        checks++;
        if (alpha !== exp_next) begin
          errors++;
          $display("FAIL issue_alpha #%0d got %h exp %h", iss, alpha, exp_next);
        end
        sb_q.push_back(exp_next);
        pipe_q.push_back('{c + lat, alpha});
        exp_next = mulx(exp_next);
        iss++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0 || pipe_q.size() == 0) begin
          errors++;
          $display("FAIL retire_empty c=%0d got retire exp none", c);
        end else begin
          e = sb_q.pop_front();
          p = pipe_q.pop_front();
          if (oldalpha !== e || p.tw !== e) begin
            errors++;
            $display("FAIL retire_tweak #%0d got %h exp %h", ret, oldalpha, e);
          end
        end
        ret++;
        last_ret_c = c;
      end
      if (iss - ret > peak) peak = iss - ret;
      if (done_c >= 0 && c == done_c + 1) begin
        busy_after = busy;
        fin = 1;
      end
      if (aborted && c == abort_c + 1) begin
        busy_after = busy;
        fin = 1;
      end
      if (abort) aborted = 1;
      s_ud = tk_ud; s_rd = tk_read; s_wr = tk_write; s_t0 = tweak_0;
      @(posedge clk);
      if (s_ud) begin
        alpha = s_t0;
        oldalpha = s_t0;
      end else begin
        if (s_rd) alpha = mulx(alpha);
        if (s_wr) oldalpha = mulx(oldalpha);
      end
      @(negedge clk);
    end
    start = 0; abort = 0; in_valid = 0; res_valid = 0; out_ready = 0;
    if (aborted) pipe_q.delete();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, res_ready, out_valid, tk_ud, tk_read,
         tk_write, busy, done} !== 8'b0 || tweak_0 !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%h exp 0", {in_ready, res_ready,
               out_valid, tk_ud, tk_read, tk_write, busy, done}, tweak_0);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy got %b exp 0", busy);
    end
  endtask

  task automatic test_basic();
    run_unit(3, 128'h1, 2, 999, 0, -1, 40);
    checks++;
    if (ud_c !== 1 || n_ud !== 1) begin
      errors++;
      $display("FAIL basic_tk_ud got c=%0d n=%0d exp c=1 n=1", ud_c, n_ud);
    end
    checks++;
    if (n_rd !== 3) begin
      errors++;
      $display("FAIL basic_tk_read got %0d exp 3", n_rd);
    end
    checks++;
    if (n_wr !== 3) begin
      errors++;
      $display("FAIL basic_tk_write got %0d exp 3", n_wr);
    end
    checks++;
    if (n_done !== 1 || done_c !== 7) begin
      errors++;
      $display("FAIL basic_done got n=%0d c=%0d exp n=1 c=7", n_done, done_c);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_after got %b exp 0", busy_after);
    end
  endtask

  task automatic test_credit_stall();
    run_unit(10, 128'h8000_0000_0000_0000_0000_0000_0000_0003,
             8, 999, 0, -1, 120);
    checks++;
    if (peak !== MAXI) begin
      errors++;
      $display("FAIL credit_peak got %0d exp %0d", peak, MAXI);
    end
    checks++;
    if (n_wr !== 10 || n_done !== 1) begin
      errors++;
      $display("FAIL credit_done got wr=%0d done=%0d exp 10/1", n_wr, n_done);
    end
`ifdef XTS_PERF_EN
    checks++;
    if (stall_cnt === 32'd0 || stall_cnt !== exp_stall) begin
      errors++;
      $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, exp_stall);
    end
`endif
  endtask

  task automatic test_backpressure();
    run_unit(10, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
             2, 6, 5, -1, 120);
    checks++;
    if (bp_viol !== 0) begin
      errors++;
      $display("FAIL bp_retire got %0d exp 0", bp_viol);
    end
    checks++;
    if (n_wr !== 10) begin
      errors++;
      $display("FAIL bp_tk_write got %0d exp 10", n_wr);
    end
    checks++;
    if (n_done !== 1 || done_c !== last_ret_c + 1) begin
      errors++;
      $display("FAIL bp_done got c=%0d exp c=%0d", done_c, last_ret_c + 1);
    end
  endtask

  task automatic test_zero_len();
    run_unit(0, 128'hdead, 2, 999, 0, -1, 20);
    checks++;
    if (n_ud !== 0 || n_rd !== 0 || n_wr !== 0) begin
      errors++;
      $display("FAIL zero_strobes got %0d/%0d/%0d exp 0/0/0",
               n_ud, n_rd, n_wr);
    end
    checks++;
    if (n_done !== 1 || done_c !== 1) begin
      errors++;
      $display("FAIL zero_done got n=%0d c=%0d exp n=1 c=1", n_done, done_c);
    end
  endtask

  task automatic test_abort();
    run_unit(4, 128'h55, 8, 999, 0, 12, 40);
    checks++;
    if (abort_infl !== 2) begin
      errors++;
      $display("FAIL abort_inflight got %0d exp 2", abort_infl);
    end
    checks++;
    if (busy_after !== 1'b0 || n_done !== 0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b done=%0d exp 0/0",
               busy_after, n_done);
    end
    run_unit(1, 128'h77, 2, 999, 0, -1, 20);
    checks++;
    if (n_done !== 1 || n_rd !== 1 || n_wr !== 1) begin
      errors++;
      $display("FAIL abort_restart got %0d/%0d/%0d exp 1/1/1",
               n_done, n_rd, n_wr);
    end
  endtask

  task automatic test_async_reset();
    start = 1; num_blocks = 16'd10; tweak_in = 128'h9;
    in_valid = 1; out_ready = 1; res_valid = 0;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    res_valid = 1;
    #1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got busy=%b ov=%b exp 1/1", busy, out_valid);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, res_ready, out_valid, tk_ud, tk_read,
         tk_write, busy, done} !== 8'b0 || tweak_0 !== '0) begin
      errors++;
      $display("FAIL arst_outputs got %b/%h exp 0", {in_ready, res_ready,
               out_valid, tk_ud, tk_read, tk_write, busy, done}, tweak_0);
    end
    start = 1; num_blocks = 16'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_start got busy=%b exp 0", busy);
    end
    start = 0; in_valid = 0; out_ready = 0; res_valid = 0;
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_release got busy=%b exp 0", busy);
    end
    run_unit(2, 128'h1234, 3, 999, 0, -1, 30);
    checks++;
    if (n_done !== 1 || n_wr !== 2) begin
      errors++;
      $display("FAIL arst_after got done=%0d wr=%0d exp 1/2", n_done, n_wr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_stall();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
